regfile_mp: RTL

Parametrised multi-port register file; successor to the lab03 two-read/one-write regfile. Provides NUM_READ synchronous read ports and two write ports with write-first bypass. Architectural register 0 is optionally hardwired to zero. A reset-triggered clear sweep zeroes storage one entry per cycle, so the array maps to distributed/block RAM. Sits in the datapath of the dual-issue pipeline.

---
 rtl/regfile_mp_pkg.sv | 37 +++
 rtl/regfile_mp_if.sv | 35 +++
 rtl/regfile_mp_readport.sv | 54 +++++
 rtl/regfile_mp.sv | 107 ++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package regfile_mp_pkg;

    // CLEAR zeroes one entry per cycle after reset; READY is normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    // Widest data bus the forwarding helper handles; callers zero-extend
    // their data to this width and truncate the result back.
    localparam int RF_MAX_W = 64;

    function automatic int calc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Write-first forwarding: port 1 beats port 0, and either beats storage.
    function automatic logic [RF_MAX_W-1:0] bypass_select(
        input logic                hit0,
        input logic                hit1,
        input logic [RF_MAX_W-1:0] wr_dat0,
        input logic [RF_MAX_W-1:0] wr_dat1,
        input logic [RF_MAX_W-1:0] mem_dat
    );
        if (hit1) begin
            return wr_dat1;
        end
        if (hit0) begin
            return wr_dat0;
        end
        return mem_dat;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, two write ports, sweep status.
// Latency: n/a (wiring only); read data is registered inside the register file.
// Backpressure: none; writes and reads are accepted every cycle once the sweep is done.
//
// Signals: readReg/readData (NUM_READ packed lanes), write0/1 + writeReg0/1 +
// writeData0/1, init_busy.  master = requester side, slave = register file.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH     = 32,
    parameter int NUM_READ  = 2,
    parameter int ADDR_W    = calc_addr_w(DEPTH)
);
    logic [NUM_READ-1:0][ADDR_W-1:0]    readReg;
    logic [NUM_READ-1:0][BUS_WIDTH-1:0] readData;
    logic                               write0;
    logic [ADDR_W-1:0]                  writeReg0;
    logic [BUS_WIDTH-1:0]               writeData0;
    logic                               write1;
    logic [ADDR_W-1:0]                  writeReg1;
    logic [BUS_WIDTH-1:0]               writeData1;
    logic                               init_busy;

    modport master (
        output readReg, write0, writeReg0, writeData0, write1, writeReg1, writeData1,
        input  readData, init_busy
    );

    modport slave (
        input  readReg, write0, writeReg0, writeData0, write1, writeReg1, writeData1,
        output readData, init_busy
    );

endinterface

// File: rtl/regfile_mp_readport.sv
// One registered read port with write-first bypass against both write ports.
// Latency: 1 cycle from raddr to rdata.
// Backpressure: none; outputs 0 while reset or the clear sweep is active.
//
// Ports: clk, rst, busy (sweep active), raddr, mem_dat (array at raddr),
// we0/waddr0/wdata0 and we1/waddr1/wdata1 (already qualified writes), rdata.
module regfile_mp_readport
    import regfile_mp_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 busy,
    input  logic [ADDR_W-1:0]    raddr,
    input  logic [BUS_WIDTH-1:0] mem_dat,
    input  logic                 we0,
    input  logic [ADDR_W-1:0]    waddr0,
    input  logic [BUS_WIDTH-1:0] wdata0,
    input  logic                 we1,
    input  logic [ADDR_W-1:0]    waddr1,
    input  logic [BUS_WIDTH-1:0] wdata1,
    output logic [BUS_WIDTH-1:0] rdata
);

    logic                 hit0;
    logic                 hit1;
    logic                 is_zero;
    logic [BUS_WIDTH-1:0] fwd_dat;

    // we0/we1 arrive with dropped writes (sweep, register 0) already masked,
    // so a hit here is always a write that really commits this cycle.
    assign hit0    = we0 && (waddr0 == raddr);
    assign hit1    = we1 && (waddr1 == raddr);
    assign is_zero = (ZERO_REG != 0) && (raddr == '0);

    assign fwd_dat = BUS_WIDTH'(bypass_select(hit0, hit1,
                                              RF_MAX_W'(wdata0),
                                              RF_MAX_W'(wdata1),
                                              RF_MAX_W'(mem_dat)));

    always_ff @(posedge clk) begin
        if (rst || busy) begin
            rdata <= '0;
        end else if (is_zero) begin
            rdata <= '0;
        end else begin
            rdata <= fwd_dat;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ registered read ports, two write ports, post-reset clear sweep.
// Latency: 1 cycle read; writes visible same cycle via bypass, in storage next cycle.
// Backpressure: none; init_busy high for DEPTH cycles after reset, writes ignored meanwhile.
//
// Ports: clk, rst (synchronous, active-high), bus (regfile_mp_if.slave) carrying
// readReg/readData, write0/1 with writeReg0/1 and writeData0/1, init_busy.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH     = 32,
    parameter int NUM_READ  = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);

    localparam int ADDR_W = calc_addr_w(DEPTH);

    rf_state_t            state;
    logic [ADDR_W-1:0]    clr_cnt;
    logic                 init_busy_q;
    logic [BUS_WIDTH-1:0] mem [DEPTH];

    logic                 we0_eff;
    logic                 we1_eff;
    logic                 drop0;
    logic                 drop1;

    // Writes to register 0 vanish when it is hardwired; also hide them from
    // the bypass so a forwarded value can never leak out as register 0.
    assign drop0   = (ZERO_REG != 0) && (bus.writeReg0 == '0);
    assign drop1   = (ZERO_REG != 0) && (bus.writeReg1 == '0);
    assign we0_eff = (state == READY) && bus.write0 && !drop0;
    assign we1_eff = (state == READY) && bus.write1 && !drop1;

    assign bus.init_busy = init_busy_q;

    // Clear sweep FSM. init_busy_q tracks CLEAR exactly, held as a flop so
    // the status output comes straight from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state       <= READY;
                        init_busy_q <= 1'b0;
                    end
                end
                READY: begin
                    state       <= READY;
                    init_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset term so it can map onto RAM; the sweep zeroes it
    // one entry per cycle instead. Port 1 is written last so it wins a
    // same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end
            if (we0_eff) begin
                mem[bus.writeReg0] <= bus.writeData0;
            end
            if (we1_eff) begin
                mem[bus.writeReg1] <= bus.writeData1;
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [BUS_WIDTH-1:0] rd_dat;

        regfile_mp_readport #(
            .BUS_WIDTH (BUS_WIDTH),
            .ADDR_W    (ADDR_W),
            .ZERO_REG  (ZERO_REG)
        ) u_rp (
            .clk     (clk),
            .rst     (rst),
            .busy    (init_busy_q),
            .raddr   (bus.readReg[p]),
            .mem_dat (mem[bus.readReg[p]]),
            .we0     (we0_eff),
            .waddr0  (bus.writeReg0),
            .wdata0  (bus.writeData0),
            .we1     (we1_eff),
            .waddr1  (bus.writeReg1),
            .wdata1  (bus.writeData1),
            .rdata   (rd_dat)
        );

        assign bus.readData[p] = rd_dat;
    end

endmodule
